// File: rtl/bram_sweep_fsm_pkg.sv
// Shared types and constants for the BRAM fill/sweep sequencer and its hold timer.
// The state encoding is also used by anything that observes the debug state output.
package bram_sweep_fsm_pkg;

  localparam int DATA_W              = 16;
  localparam int DEFAULT_HOLD_CYCLES = 50_000_000;  // one second of display time at 50 MHz

  typedef enum logic [2:0] {
    ST_FILL = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WB   = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

endpackage

// File: rtl/bram_sweep_fsm_hold_timer.sv
// Loadable down counter that measures how long each swept word stays on the display.
// done is high during the final cycle of the hold window.
module hold_timer
  import bram_sweep_fsm_pkg::*;
#(
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic done
);

  localparam int              CW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]   LOAD_VAL = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Loaded with HOLD_CYCLES-1 so that the count reaching zero marks the last hold cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = enable && (cnt == '0);

endmodule

// File: rtl/bram_sweep_fsm.sv
// Fills a block RAM with BASE+addr, then endlessly reads, increments and writes back each
// word, holding every new value on out for HOLD_CYCLES cycles.
module bram_sweep_fsm
  import bram_sweep_fsm_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          NUM_WORDS   = 16,
  parameter logic [15:0] BASE        = 16'h1000,
  parameter int          HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       out,
  output logic [7:0]        pass,
  output state_t            dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic [7:0]          pass_q, pass_d;
  logic                we_c;
  logic [DATA_W-1:0]   wdata_c;
  logic [DATA_W-1:0]   rdata_inc;
  logic                hold_load, hold_en, hold_done;

  assign rdata_inc = mem_rdata + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FILL;
      addr_q  <= '0;
      out_q   <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    out_d     = out_q;
    pass_d    = pass_q;
    we_c      = 1'b0;
    wdata_c   = '0;
    hold_load = 1'b0;
    hold_en   = 1'b0;
    case (state_q)
      ST_FILL: begin
        we_c    = 1'b1;
        wdata_c = BASE + DATA_W'(addr_q);
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = ST_RD;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_RD:   state_d = ST_WAIT;
      ST_WAIT: state_d = ST_WB;
      ST_WB: begin
        // RAM output has been valid since WAIT; the write-back reuses the held address.
        we_c      = 1'b1;
        wdata_c   = rdata_inc;
        out_d     = rdata_inc;
        hold_load = 1'b1;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        hold_en = 1'b1;
        if (hold_done) begin
          state_d = ST_RD;
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            pass_d = pass_q + 8'd1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_FILL;
        addr_d  = '0;
      end
    endcase
  end

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (hold_load),
    .enable (hold_en),
    .done   (hold_done)
  );

  // Write strobe and data are forced low while reset is held, so the first write
  // appears as soon as reset releases and nothing is written during reset.
  assign mem_we    = rst & we_c;
  assign mem_wdata = rst ? wdata_c : '0;
  assign mem_addr  = addr_q;
  assign out       = out_q;
  assign pass      = pass_q;
  assign dbg_state = state_q;

endmodule

// File: doc/bram_sweep_fsm.md
# bram_sweep_fsm

- Sequencer directly upstream of the four-digit hex display stage; its 16-bit `out` feeds the four 7-segment decoders.
- Fills a block of single-clock, one-cycle-read-latency block RAM with a known pattern, then sweeps it forever.
- Each sweep step reads a word, increments it, writes it back and holds the result on `out` long enough to be read on the board.

## Interface
Parameters:
- ADDR_W, 10, memory address width
- NUM_WORDS, 16, words swept (1 ≤ NUM_WORDS ≤ 2^ADDR_W)
- BASE, 16'h1000, fill pattern offset
- HOLD_CYCLES, 50_000_000, display hold per word (≥ 1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  16  RAM write data
- mem_rdata  in  16  RAM read data, valid one cycle after address is presented with mem_we=0
- out  out  16  value shown on the display
- pass  out  8  completed sweep count, wraps 255→0

## Operation
States:
- FILL
  - Writes mem_wdata = BASE + addr (16-bit wrap) at addr 0..NUM_WORDS-1, one write per cycle, mem_we=1.
  - After the write to NUM_WORDS-1: addr ← 0, go to RD.
- RD
  - Presents addr with mem_we=0; go to WAIT.
- WAIT
  - Address held, mem_we=0; go to WB.
- WB
  - Captures mem_rdata.
  - Drives mem_wdata = rdata+1 (16-bit wrap, FFFF→0000) with mem_we=1 at the same addr.
  - out ← rdata+1; hold counter loaded; go to HOLD.
- HOLD
  - mem_we=0; count HOLD_CYCLES cycles.
  - On expiry:
    - If addr = NUM_WORDS-1: addr ← 0 and pass ← pass+1.
    - Otherwise: addr ← addr+1.
  - Go to RD.

Rules:
- mem_we is asserted only in FILL and WB, never in any other state.
- out changes only on the edge leaving WB and on reset.
- Arithmetic is 16-bit modular; addr compare uses NUM_WORDS-1 zero-extended to ADDR_W.
- NUM_WORDS=1: the sweep revisits addr 0 every step; pass increments every step.
- Reset mid-operation (any state):
  - Immediately returns to FILL with addr 0.
  - RAM contents are not cleared; the refill overwrites them.

## Timing
- Reset values (asynchronous on rst low): state FILL, mem_addr 0, mem_we 0, mem_wdata 0, out 0, pass 0, hold counter 0.
- First cycle after rst deasserts: mem_we=1, mem_addr=0, mem_wdata=BASE.
- Fill occupies exactly NUM_WORDS cycles.
- Each sweep step is HOLD_CYCLES+3 cycles: RD 1, WAIT 1, WB 1, HOLD HOLD_CYCLES.
- out updates 3 cycles after RD is entered for that word.
- mem_rdata is sampled only in WB; its value in other states is ignored.
- Write-back in WB and the next read of the same addr are ≥ HOLD_CYCLES+1 cycles apart, so there are no read-during-write hazards.

## Structure
- Shared package:
  - State encoding (FILL, RD, WAIT, WB, HOLD; 3-bit).
  - Display data width constant (16).
  - Default HOLD_CYCLES for 50 MHz.
- Sub-module `hold_timer`:
  - Loadable down counter, width $clog2(HOLD_CYCLES+1).
  - Inputs: load, enable.
  - Output: done, asserted in the last HOLD cycle.
- The top-level board wrapper instantiates this block, the RAM, and the display decoders.

## Test plan
All scenarios use NUM_WORDS=4, HOLD_CYCLES=3, BASE=16'h1000, with a behavioural one-cycle-latency RAM.
- Reset, release: cycles 1-4 write 1000,1001,1002,1003 at addr 0-3; out=0000 and pass=0 throughout.
- First sweep: out sequence 1001,1002,1003,1004, changing every 6 cycles; RAM ends holding 1001..1004; pass=1 after the addr-3 HOLD expires.
- Second sweep: out 1002..1005; pass=2; mem_we high only in FILL/WB cycles, checked by assertion every cycle.
- Wrap: preload RAM addr 0 with FFFF after fill (force) -> out shows 0000 and RAM addr 0 reads 0000.
- Reset asserted during HOLD of addr 2 -> outputs zero immediately (asynchronous); after release FILL restarts at addr 0 and out follows 1001.. again.
- NUM_WORDS=1 -> out 1001,1002,1003 on successive steps; pass increments every step.
